multdiv_sequencer: RTL and testbench

Execute-stage sequencer for the multicycle multiply/divide core. It sits between the decode/control logic and the external multdiv unit. It receives the mult/div assertions and the DX operand latches, and launches the multdiv core with a single-cycle start pulse. While the operation runs it stalls PC, FD and DX and inserts a bubble into XM, then hands a registered result and rstatus exception code to the XM latch.

---
 rtl/multdiv_sequencer.sv | 132 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the multicycle multiply/divide core.
// Latches the DX operands, fires a one-cycle start pulse at the core, stalls the
// front of the pipeline while the core runs, and presents a registered result
// plus rstatus code for exactly one cycle so the instruction can enter XM.
module multdiv_sequencer #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        assert_mult,
  input  logic        assert_div,
  input  logic [31:0] DX_Latch_A,
  input  logic [31:0] DX_Latch_B,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception_valid,
  output logic [31:0] rstatus_value,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             op;        // 0 = multiply, 1 = divide
  logic [CNT_W-1:0] cnt;
  logic             exc_q;
  logic             to_q;
  logic             any_req;
  logic             cnt_last;
  logic [31:0]      exc_code;

  assign any_req  = assert_mult | assert_div;
  assign cnt_last = (cnt == CNT_LAST);
  assign exc_code = op ? 32'd5 : 32'd4;

  // State register; reset is asynchronous so the start pulses drop immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a dropped request in START/BUSY is a pipeline flush and
  // takes priority over a ready arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = START;
      START:   state_nxt = any_req ? BUSY : IDLE;
      BUSY: begin
        if (!any_req)                     state_nxt = IDLE;
        else if (md_resultRDY || cnt_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/op latch, watchdog counter and the result hand-off registers.
  // Result, rstatus and flags are cleared on every edge that does not enter
  // DONE, so they are only ever non-zero during the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op            <= 1'b0;
      cnt           <= '0;
      md_operandA   <= '0;
      md_operandB   <= '0;
      result        <= '0;
      rstatus_value <= '0;
      exc_q         <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      result        <= '0;
      rstatus_value <= '0;
      exc_q         <= 1'b0;
      to_q          <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            op          <= ~assert_mult;
            md_operandA <= DX_Latch_A;
            md_operandB <= DX_Latch_B;
          end
        end
        START: cnt <= '0;
        BUSY: begin
          if (!cnt_last) cnt <= cnt + 1'b1;
          if (any_req) begin
            if (md_resultRDY) begin
              result        <= md_result;
              exc_q         <= md_exception;
              rstatus_value <= md_exception ? exc_code : 32'd0;
            end else if (cnt_last) begin
              result        <= '0;
              exc_q         <= 1'b1;
              to_q          <= 1'b1;
              rstatus_value <= exc_code;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs plus the combinational stall seen in the first DX cycle.
  always_comb begin
    md_ctrl_MULT    = (state == START) & ~op;
    md_ctrl_DIV     = (state == START) & op;
    stall           = any_req & (state != DONE);
    result_valid    = (state == DONE);
    exception_valid = (state == DONE) & exc_q;
    timeout         = (state == DONE) & to_q;
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed scenarios with literal
// expectations, then randomized operations, all compared cycle-by-cycle
// against a behavioural model of the sequencer.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        assert_mult = 1'b0;
  logic        assert_div = 1'b0;
  logic [31:0] DX_Latch_A = '0;
  logic [31:0] DX_Latch_B = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        exception_valid;
  logic [31:0] rstatus_value;
  logic        timeout;

  multdiv_sequencer #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .assert_mult(assert_mult), .assert_div(assert_div),
    .DX_Latch_A(DX_Latch_A), .DX_Latch_B(DX_Latch_B),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .stall(stall), .result(result), .result_valid(result_valid),
    .exception_valid(exception_valid), .rstatus_value(rstatus_value),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the instruction is in its life (waiting in DX,
  // launching, running on the core, handing off), how many running cycles have
  // elapsed, and what the hand-off must present.
  localparam int PH_WAIT = 0, PH_LAUNCH = 1, PH_RUN = 2, PH_HANDOFF = 3;
  int          m_ph   = PH_WAIT;
  int          m_age  = 0;
  logic        m_div  = 1'b0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_code = '0;
  logic        m_exc  = 1'b0;
  logic        m_to   = 1'b0;
  wire         req    = assert_mult | assert_div;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph <= PH_WAIT; m_age <= 0; m_div <= 1'b0; m_a <= '0; m_b <= '0;
      m_res <= '0; m_code <= '0; m_exc <= 1'b0; m_to <= 1'b0;
    end else begin
      m_res <= '0; m_code <= '0; m_exc <= 1'b0; m_to <= 1'b0;
      if (m_ph == PH_WAIT) begin
        if (req) begin
          m_ph <= PH_LAUNCH; m_div <= !assert_mult; m_a <= DX_Latch_A; m_b <= DX_Latch_B;
        end
      end else if (m_ph == PH_LAUNCH) begin
        m_ph <= req ? PH_RUN : PH_WAIT;
        m_age <= 0;
      end else if (m_ph == PH_RUN) begin
        m_age <= m_age + 1;
        if (!req) m_ph <= PH_WAIT;
        else if (md_resultRDY) begin
          m_ph <= PH_HANDOFF; m_res <= md_result; m_exc <= md_exception;
          m_code <= md_exception ? (m_div ? 32'd5 : 32'd4) : 32'd0;
        end else if (m_age + 1 == MAXC) begin
          m_ph <= PH_HANDOFF; m_exc <= 1'b1; m_to <= 1'b1;
          m_code <= m_div ? 32'd5 : 32'd4;
        end
      end else begin
        m_ph <= PH_WAIT;
      end
    end
  end

  always @(negedge clock) begin
    check("mult_pulse", md_ctrl_MULT, (m_ph == PH_LAUNCH) && !m_div);
    check("div_pulse", md_ctrl_DIV, (m_ph == PH_LAUNCH) && m_div);
    check("stall", stall, req && (m_ph != PH_HANDOFF));
    check("result_valid", result_valid, m_ph == PH_HANDOFF);
    check("result", result, (m_ph == PH_HANDOFF) ? m_res : 32'd0);
    check("exception_valid", exception_valid, (m_ph == PH_HANDOFF) && m_exc);
    check("rstatus", rstatus_value, (m_ph == PH_HANDOFF) ? m_code : 32'd0);
    check("timeout", timeout, (m_ph == PH_HANDOFF) && m_to);
    check("operandA", md_operandA, m_a);
    check("operandB", md_operandB, m_b);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accepted operation. lat = cycles after START at which the core is
  // ready (0 = never). Enters and leaves in an IDLE cycle.
  task automatic run_op(input bit is_div, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input bit exc, input bit spur,
                        input bit keep, input logic [31:0] exp_res,
                        input logic [31:0] exp_code, input bit exp_to);
    logic [31:0] core;
    int cyc;
    core = is_div ? ((b == 0) ? 32'd0 : a / b) : a * b;
    assert_mult = !is_div || both;
    assert_div  = is_div || both;
    DX_Latch_A = a;
    DX_Latch_B = b;
    #1 check("stall_first_dx", stall, 1);
    step();
    #1 check("start_pulse", is_div ? md_ctrl_DIV : md_ctrl_MULT, 1);
    if (spur) begin md_resultRDY = 1'b1; md_result = 32'hdeadbeef; end
    step();
    md_resultRDY = 1'b0;
    if (lat == 0) begin
      cyc = 0;
      while (!result_valid && cyc < MAXC + 20) begin step(); cyc++; end
      check("timeout_cycles", cyc, MAXC);
    end else begin
      repeat (lat - 1) step();
      md_resultRDY = 1'b1; md_result = core; md_exception = exc;
      #1 check("stall_ready_cycle", stall, 1);
      step();
      md_resultRDY = 1'b0; md_exception = 1'b0;
    end
    #1;
    check("done_valid", result_valid, 1);
    check("done_result", result, exp_res);
    check("done_exc", exception_valid, exp_code != 0);
    check("done_rstatus", rstatus_value, exp_code);
    check("done_timeout", timeout, exp_to);
    check("done_stall", stall, 0);
    if (!keep) begin assert_mult = 1'b0; assert_div = 1'b0; end
    step();
  endtask

  // Operation flushed after nbusy BUSY cycles, then a late ready from the core.
  task automatic run_flush(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                           input int nbusy);
    assert_mult = !is_div; assert_div = is_div;
    DX_Latch_A = a; DX_Latch_B = b;
    step();
    repeat (nbusy) step();
    assert_mult = 1'b0; assert_div = 1'b0;
    #1 check("flush_stall", stall, 0);
    step();
    md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'b1;
    step();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    #1;
    check("flush_no_valid", result_valid, 0);
    check("flush_no_exc", exception_valid, 0);
    check("flush_stall_idle", stall, 0);
    check("flush_no_pulse", md_ctrl_MULT | md_ctrl_DIV, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit          d, both, exc, spur, keep;
    logic [31:0] a, b, core;
    int          lat;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("reset_result", result, 0);
    check("reset_stall", stall, 0);
    check("reset_opA", md_operandA, 0);
    check("reset_rstatus", rstatus_value, 0);
    check("reset_valid", result_valid, 0);

    run_op(0, 0, 7, 6, 3, 0, 0, 0, 32'd42, 32'd0, 0);
    run_op(1, 0, 5, 0, 4, 1, 0, 0, 32'd0, 32'd5, 0);
    run_op(0, 0, 32'h40000000, 4, 2, 1, 0, 0, 32'd0, 32'd4, 0);
    run_op(0, 0, 2, 3, 0, 0, 0, 0, 32'd0, 32'd4, 1);
    run_op(1, 0, 9, 3, 0, 0, 0, 0, 32'd0, 32'd5, 1);
    run_op(0, 0, 12, 12, 1, 0, 0, 1, 32'd144, 32'd0, 0);
    run_op(1, 0, 100, 7, 5, 0, 1, 0, 32'd14, 32'd0, 0);
    run_op(0, 1, 3, 5, 2, 0, 0, 0, 32'd15, 32'd0, 0);
    run_flush(0, 9, 9, 3);
    run_flush(1, 1, 1, 0);

    // asynchronous reset between edges while BUSY
    assert_mult = 1'b1; DX_Latch_A = 3; DX_Latch_B = 9;
    step(); step(); step();
    #2 reset = 1'b1; assert_mult = 1'b0;
    #1;
    check("areset_pulse", md_ctrl_MULT, 0);
    check("areset_stall", stall, 0);
    check("areset_valid", result_valid, 0);
    check("areset_opA", md_operandA, 0);
    check("areset_opB", md_operandB, 0);
    check("areset_result", result, 0);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;
    run_op(0, 0, 11, 13, 2, 0, 0, 0, 32'd143, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_flush($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 4));
      end else begin
        d    = ($urandom_range(0, 1) == 1);
        both = !d && ($urandom_range(0, 3) == 0);
        a    = $urandom;
        b    = d ? (($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000))) : $urandom;
        lat  = $urandom_range(1, 8);
        exc  = ($urandom_range(0, 4) == 0) || (d && b == 0);
        spur = ($urandom_range(0, 2) == 0);
        keep = ($urandom_range(0, 1) == 1);
        core = d ? ((b == 0) ? 32'd0 : a / b) : a * b;
        run_op(d, both, a, b, lat, exc, spur, keep, core,
               exc ? (d ? 32'd5 : 32'd4) : 32'd0, 0);
      end
    end

    assert_mult = 1'b0; assert_div = 1'b0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
